seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width.
REQ-002 SHALL have parameter ITER_CNT, default 16, giving the MUL/DIV iteration count; it SHALL equal WIDTH.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin the operation; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASSB, 5 INC, 6 MUL, 7 DIV.
REQ-007 SHALL have port operand_a, input, WIDTH bits: first operand, the AC output.
REQ-008 SHALL have port operand_b, input, WIDTH bits: second operand, the data-bus value.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid; drives the AC alu_out/write strobe.
REQ-011 SHALL have port result, output, WIDTH bits: registered result, feeding AC data_in_alu.
REQ-012 SHALL have ports zero, neg, carry and div0, outputs, 1 bit each: registered flags.

Function
REQ-013 SHALL implement states IDLE, EXEC, ITER and DONE.
REQ-014 In IDLE with start=1, SHALL capture op, operand_a and operand_b, then go to EXEC for ops 0-5 or to ITER for ops 6-7.
REQ-015 EXEC SHALL compute the single-cycle op, register result and flags, and go to DONE; done SHALL be high exactly 2 cycles after the start-sampling edge.
REQ-016 ITER SHALL run for exactly ITER_CNT cycles with a down-counter, then go to DONE; done SHALL be high ITER_CNT+2 cycles after start.
REQ-017 DONE SHALL assert done for one cycle and return to IDLE.
REQ-018 result and flags SHALL hold their values until the next completed operation.
REQ-019 start outside IDLE SHALL be ignored, with no queuing; operand changes after capture SHALL have no effect.
REQ-020 ADD, SUB and INC SHALL be modulo 2^WIDTH; carry SHALL be the carry-out, and for SUB carry=1 SHALL mean no borrow (a>=b).
REQ-021 AND, OR and PASSB SHALL clear carry.
REQ-022 MUL SHALL be unsigned shift-add and return the low WIDTH bits; carry SHALL be set if any high product bit is nonzero.
REQ-023 DIV SHALL be unsigned restoring division and return the quotient; carry SHALL be cleared.
REQ-024 DIV with operand_b=0 SHALL still take the full ITER latency, return all-ones, and set div0; every other op SHALL clear div0.
REQ-025 zero SHALL equal (result==0) and neg SHALL equal result[WIDTH-1], both updated only on completion.

Reset
REQ-026 When reset_n=0 at a clock edge, SHALL go to IDLE and clear result, busy, done, zero, neg, carry, div0 and the counter.
REQ-027 Reset SHALL abort an in-flight EXEC or ITER, and no done pulse SHALL follow.
REQ-028 start sampled on the first edge with reset_n=1 SHALL be accepted normally.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined SHALL enable ops 6-7 and the ITER datapath as specified above.
REQ-030 Without SEQ_ALU_MULDIV_EN, SHALL omit ITER and its registers; ops 6-7 SHALL go through EXEC, return operand_a unchanged, clear carry, and set div0 as an illegal-op indication with 2-cycle latency.

Structure
REQ-031 Shared package alu_pkg SHALL hold the op encodings, the state encodings and the default width constant.
REQ-032 The iterative MUL/DIV datapath SHALL be a sub-module seq_muldiv with start, op select, operands, done and result; seq_alu SHALL own the FSM and flags.

Verification
REQ-033 ADD 0xFFFF+0x0001 -> result=0x0000, zero=1, carry=1, done 2 cycles after start.
REQ-034 SUB 5-7 -> result=0xFFFE, neg=1, carry=0; AND 0xF0F0&0x0FF0 -> result=0x00F0, carry=0.
REQ-035 MUL 300*300 -> result=0x5F90, carry=1, done at cycle 18 with busy high throughout.
REQ-036 DIV 100/7 -> result=14; DIV 9/0 -> result=0xFFFF, div0=1, latency 18.
REQ-037 start re-asserted during MUL is ignored; reset_n=0 at iteration 5 -> all outputs 0, no done, next ADD 2+3 -> result=5.
REQ-038 Without SEQ_ALU_MULDIV_EN: MUL with a=0x1234 -> result=0x1234, div0=1, done at cycle 2.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: operation encodings, FSM state
// encodings and the default datapath width.
// Configuration macro used by the importing RTL: SEQ_ALU_MULDIV_EN.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_PASSB = 3'd4,
    OP_INC   = 3'd5,
    OP_MUL   = 3'd6,
    OP_DIV   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for the operations served by the iterative multiply/divide unit.
  function automatic logic op_is_iter(input op_e o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// ----------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// clock for ITER_CNT clocks after the load cycle. Only instantiated by
// seq_alu when SEQ_ALU_MULDIV_EN is defined.
// Ports:
//   clock, reset_n  - clock, synchronous active-low reset
//   start           - load operands and begin (one-cycle pulse)
//   div_sel         - 0: multiply, 1: divide
//   a, b            - multiplier/dividend, multiplicand/divisor
//   done            - high while the final value is available
//   result          - low product half or quotient
//   carry           - multiply only: upper product half is nonzero
//   div0            - divide with a zero divisor
// ----------------------------------------------------------------------------
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int ITER_CNT = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             div0
);

  localparam int CNT_W = $clog2(ITER_CNT + 1);

  // acc_r holds {partial product, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV; both shift one bit per step.
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic               div_r;
  logic               active_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     diff_s;

  // Per-step arithmetic for both algorithms.
  always_comb begin
    add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
    shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, opb_r};
  end

  // Operand load, iteration and down-counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_r    <= '0;
      opb_r    <= '0;
      div_r    <= 1'b0;
      active_r <= 1'b0;
      cnt_r    <= '0;
    end else if (start) begin
      acc_r    <= {{WIDTH{1'b0}}, a};
      opb_r    <= b;
      div_r    <= div_sel;
      active_r <= 1'b1;
      cnt_r    <= CNT_W'(ITER_CNT);
    end else if (active_r && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
      if (div_r) begin
        // Restore (keep the shifted remainder) when the trial subtract underflows.
        // A zero divisor never underflows, so the quotient fills with ones.
        if (diff_s[WIDTH]) begin
          acc_r <= {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
          acc_r <= {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
      end else begin
        if (acc_r[0]) begin
          acc_r <= {add_s, acc_r[WIDTH-1:1]};
        end else begin
          acc_r <= {1'b0, acc_r[2*WIDTH-1:1]};
        end
      end
    end else if (active_r) begin
      // Final value was offered this cycle and is taken by the parent.
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b0;
    end
  end

  assign done   = active_r && (cnt_r == '0);
  assign result = acc_r[WIDTH-1:0];
  assign carry  = !div_r && (acc_r[2*WIDTH-1:WIDTH] != '0);
  assign div0   = div_r && (opb_r == '0);

endmodule

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
// Sequential ALU for the accumulator datapath. Single-cycle ops run through
// EXEC (done 2 clocks after start); MUL/DIV run through ITER (done
// ITER_CNT+2 clocks after start) when SEQ_ALU_MULDIV_EN is defined.
// Without SEQ_ALU_MULDIV_EN, ops 6-7 pass operand_a through with div0 set.
// Ports:
//   clock, reset_n          - clock, synchronous active-low reset
//   start, op               - request and operation code (sampled in IDLE)
//   operand_a, operand_b    - AC value and data-bus value
//   busy, done              - not-IDLE indication, one-cycle completion pulse
//   result                  - registered result
//   zero, neg, carry, div0  - registered flags, updated on completion
// ----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int ITER_CNT = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             div0
);

  if (ITER_CNT != WIDTH) begin : g_bad_iter_cnt
    $error("seq_alu: ITER_CNT must equal WIDTH");
  end

  state_e           state_r, next_state_s;
  op_e              op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r, neg_r, carry_r, div0_r, busy_r, done_r;

  logic             accept_s, commit_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] exec_res_s, fin_res_s;
  logic             exec_carry_s, exec_div0_s, fin_carry_s, fin_div0_s;

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_start_s, md_done_s, md_carry_s, md_div0_s;
  logic [WIDTH-1:0] md_result_s;

  seq_muldiv #(
    .WIDTH    (WIDTH),
    .ITER_CNT (ITER_CNT)
  ) u_muldiv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (md_start_s),
    .div_sel (op[0]),
    .a       (operand_a),
    .b       (operand_b),
    .done    (md_done_s),
    .result  (md_result_s),
    .carry   (md_carry_s),
    .div0    (md_div0_s)
  );
`endif

  assign accept_s = (state_r == ST_IDLE) && start;

  // Next-state logic and the completion strobe.
  always_comb begin
    next_state_s = state_r;
    commit_s     = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
    md_start_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (op_is_iter(op_e'(op))) begin
            next_state_s = ST_ITER;
            md_start_s   = 1'b1;
          end else begin
            next_state_s = ST_EXEC;
          end
`else
          next_state_s = ST_EXEC;
`endif
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_DONE;
        commit_s     = 1'b1;
      end
      ST_ITER: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (md_done_s) begin
          next_state_s = ST_DONE;
          commit_s     = 1'b1;
        end else begin
          next_state_s = ST_ITER;
        end
`else
        next_state_s = ST_IDLE;
`endif
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Single-cycle operations on the captured operands.
  always_comb begin
    sum_s        = '0;
    exec_res_s   = '0;
    exec_carry_s = 1'b0;
    exec_div0_s  = 1'b0;
    case (op_r)
      OP_ADD: begin
        sum_s        = {1'b0, a_r} + {1'b0, b_r};
        exec_res_s   = sum_s[WIDTH-1:0];
        exec_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        // Borrow shows up as bit WIDTH; carry means "no borrow".
        sum_s        = {1'b0, a_r} - {1'b0, b_r};
        exec_res_s   = sum_s[WIDTH-1:0];
        exec_carry_s = ~sum_s[WIDTH];
      end
      OP_AND:   exec_res_s = a_r & b_r;
      OP_OR:    exec_res_s = a_r | b_r;
      OP_PASSB: exec_res_s = b_r;
      OP_INC: begin
        sum_s        = {1'b0, a_r} + {{WIDTH{1'b0}}, 1'b1};
        exec_res_s   = sum_s[WIDTH-1:0];
        exec_carry_s = sum_s[WIDTH];
      end
      default: begin
        // MUL/DIV only reach EXEC when the iterative unit is absent.
        exec_res_s  = a_r;
        exec_div0_s = 1'b1;
      end
    endcase
  end

  // Select the value committed on completion.
  always_comb begin
    fin_res_s   = exec_res_s;
    fin_carry_s = exec_carry_s;
    fin_div0_s  = exec_div0_s;
`ifdef SEQ_ALU_MULDIV_EN
    if (state_r == ST_ITER) begin
      fin_res_s   = md_result_s;
      fin_carry_s = md_carry_s;
      fin_div0_s  = md_div0_s;
    end else begin
      fin_res_s   = exec_res_s;
      fin_carry_s = exec_carry_s;
      fin_div0_s  = exec_div0_s;
    end
`endif
  end

  // State, operand capture, registered result/flags and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
      carry_r  <= 1'b0;
      div0_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      // The pulse follows the DONE state by one clock.
      done_r  <= (state_r == ST_DONE);
      if (accept_s) begin
        op_r <= op_e'(op);
        a_r  <= operand_a;
        b_r  <= operand_b;
      end
      if (commit_s) begin
        result_r <= fin_res_s;
        zero_r   <= (fin_res_s == '0);
        neg_r    <= fin_res_s[WIDTH-1];
        carry_r  <= fin_carry_s;
        div0_r   <= fin_div0_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign zero   = zero_r;
  assign neg    = neg_r;
  assign carry  = carry_r;
  assign div0   = div0_r;

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu: directed vectors, randomized operations
// against an arithmetic reference model, ignored-start/operand-change noise,
// reset abort and reset-release start. Follows SEQ_ALU_MULDIV_EN if defined.
// ----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W     = 16;
  localparam int ITERS = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, zero, neg, carry, div0;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_res = '0;

  seq_alu #(.WIDTH(W), .ITER_CNT(ITERS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .div0      (div0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic d0,
                                output int lat);
    longint unsigned full;
    longint unsigned modulus;
    modulus = 64'd65536;
    lat = 2;
    c   = 1'b0;
    d0  = 1'b0;
    r   = '0;
    case (o)
      3'd0: begin full = longint'(a) + longint'(b); r = W'(full % modulus); c = (full >= modulus); end
      3'd1: begin full = longint'(a) + modulus - longint'(b); r = W'(full % modulus); c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = b;
      3'd5: begin full = longint'(a) + 64'd1; r = W'(full % modulus); c = (full >= modulus); end
      default: begin
`ifdef SEQ_ALU_MULDIV_EN
        lat = ITERS + 2;
        if (o == 3'd6) begin
          full = longint'(a) * longint'(b);
          r = W'(full % modulus);
          c = (full / modulus) != 64'd0;
        end else if (b == '0) begin
          r  = 16'hFFFF;
          d0 = 1'b1;
        end else begin
          r = a / b;
        end
`else
        r  = a;
        d0 = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] r;
    logic         c, d0;
    int           lat;
    model(o, a, b, r, c, d0, lat);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    for (int n = 1; n <= lat; n++) begin
      // Noise after capture: stray start pulses and changing operands.
      start     = 1'($urandom_range(0, 1));
      op        = 3'($urandom);
      operand_a = W'($urandom);
      operand_b = W'($urandom);
      @(posedge clock); #1;
      if (n < lat) begin
        check({tag, " busy"}, busy, 32'd1);
        check({tag, " early_done"}, done, 32'd0);
        if (n <= lat - 2) check({tag, " hold"}, result, prev_res);
      end
    end
    start = 1'b0;
    check({tag, " done"}, done, 32'd1);
    check({tag, " busy_end"}, busy, 32'd0);
    check({tag, " result"}, result, r);
    check({tag, " zero"}, zero, (r == '0));
    check({tag, " neg"}, neg, r[W-1]);
    check({tag, " carry"}, carry, c);
    check({tag, " div0"}, div0, d0);
    prev_res = r;
    @(posedge clock); #1;
    check({tag, " pulse"}, done, 32'd0);
    check({tag, " kept"}, result, r);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " result"}, result, 32'd0);
    check({tag, " busy"}, busy, 32'd0);
    check({tag, " done"}, done, 32'd0);
    check({tag, " zero"}, zero, 32'd0);
    check({tag, " neg"}, neg, 32'd0);
    check({tag, " carry"}, carry, 32'd0);
    check({tag, " div0"}, div0, 32'd0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c, d0;
    int           lat, ab;
    logic         saw_done;

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    prev_res = '0;

    // Start asserted together with reset release: first live edge accepts it.
    reset_n = 1'b1;
    run_op(3'd0, 16'hFFFF, 16'h0001, "add_wrap");
    run_op(3'd1, 16'd5, 16'd7, "sub_borrow");
    run_op(3'd1, 16'd7, 16'd7, "sub_equal");
    run_op(3'd2, 16'hF0F0, 16'h0FF0, "and");
    run_op(3'd3, 16'hF000, 16'h000F, "or");
    run_op(3'd4, 16'h1357, 16'h8642, "passb");
    run_op(3'd5, 16'hFFFF, 16'h0000, "inc_wrap");
    run_op(3'd6, 16'd300, 16'd300, "mul");
    run_op(3'd7, 16'd100, 16'd7, "div");
    run_op(3'd7, 16'd9, 16'd0, "div_zero");
    run_op(3'd6, 16'h1234, 16'h0001, "mul_1234");
    run_op(3'd0, 16'd1, 16'd2, "add_clears_div0");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), "rand");
    end

    // Abort an in-flight MUL with reset.
    model(3'd6, 16'd300, 16'd300, r, c, d0, lat);
    ab = (lat > 6) ? 5 : lat - 1;
    start = 1'b1; op = 3'd6; operand_a = 16'd300; operand_b = 16'd300;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 0; n < ab; n++) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_cleared("abort");
    reset_n = 1'b1;
    prev_res = '0;
    saw_done = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", saw_done, 32'd0);
    check("abort idle", busy, 32'd0);
    run_op(3'd0, 16'd2, 16'd3, "add_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
